// File: rtl/collector_drain_if.sv
// ---------------------------------------------------------------------------
// collector_drain_if
// Bundle of the collector-side and consumer-side signals of the drain
// scheduler.
//   src_rdy   : per-source FIFO non-empty (head word valid on src_rdata)
//   src_rdata : per-source head words, source i at [i*DATAW +: DATAW]
//   src_ren   : per-source pop, one-hot or zero
//   out_valid : downstream word valid
//   out_data  : downstream word
//   out_src   : source index of the current word
//   out_last  : final beat of burst, qualified by out_valid
//   out_ready : downstream accept
// master = scheduler side, slave = FIFO/consumer environment side.
// ---------------------------------------------------------------------------
interface collector_drain_if #(
  parameter int NUM_SRC = 4,
  parameter int DATAW   = 512
);
  localparam int SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]       src_rdy;
  logic [NUM_SRC*DATAW-1:0] src_rdata;
  logic [NUM_SRC-1:0]       src_ren;
  logic                     out_valid;
  logic [DATAW-1:0]         out_data;
  logic [SRCW-1:0]          out_src;
  logic                     out_last;
  logic                     out_ready;

  modport master (
    input  src_rdy, src_rdata, out_ready,
    output src_ren, out_valid, out_data, out_src, out_last
  );

  modport slave (
    output src_rdy, src_rdata, out_ready,
    input  src_ren, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/collector_drain_sched.sv
// ---------------------------------------------------------------------------
// collector_drain_sched
// Round-robin drain scheduler: shares one downstream consumer port among
// NUM_SRC first-word-fall-through collector FIFOs. One source is granted at
// a time and a burst of cfg_burst_len words is moved from it; a starved
// burst is released after cfg_timeout consecutive empty cycles.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cfg_burst_len  : words per grant, sampled at grant, 0 treated as 1
//   cfg_timeout    : starved-cycle limit within a burst, 0 disables
//   burst_abort    : 1-cycle pulse when a burst is released by timeout
//   busy           : high while a burst is in progress
//   bus            : collector_drain_if master (FIFO heads/pops, consumer
//                    valid/ready/data/src/last)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate among ready sources, no data moves
// BURST | grant held; forward words from the granted source
// ---------------------------------------------------------------------------
module collector_drain_sched #(
  parameter int NUM_SRC = 4,
  parameter int DATAW   = 512,
  parameter int BLW     = 8,
  parameter int TOW     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLW-1:0]     cfg_burst_len,
  input  logic [TOW-1:0]     cfg_timeout,
  output logic               burst_abort,
  output logic               busy,
  collector_drain_if.master  bus
);
  localparam int SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SRCW-1:0] grant_q, grant_d;
  logic [SRCW-1:0] rr_q, rr_d;
  logic [BLW-1:0]  len_q, len_d;
  logic [BLW-1:0]  beat_q, beat_d;
  logic [TOW-1:0]  stall_q, stall_d;
  logic            abort_q, abort_d;

  // Round-robin pick: first ready source above the last one served.
  logic            any_rdy;
  logic [SRCW-1:0] pick;
  int              idx;

  always_comb begin
    any_rdy = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (!any_rdy && bus.src_rdy[idx]) begin
        any_rdy = 1'b1;
        pick    = SRCW'(idx);
      end
    end
  end

  logic             in_burst;
  logic             cur_rdy;
  logic             hs;
  logic             last_beat;

  assign in_burst  = (state_q == S_BURST);
  assign cur_rdy   = bus.src_rdy[grant_q];
  assign last_beat = (beat_q == (len_q - 1'b1));
  assign hs        = in_burst & cur_rdy & bus.out_ready;

  assign bus.out_valid = in_burst & cur_rdy;
  // Data follows the granted head word directly; the FIFO holds it steady
  // until popped, which keeps it stable under backpressure.
  assign bus.out_data  = bus.src_rdata[int'(grant_q)*DATAW +: DATAW];
  assign bus.out_src   = in_burst ? grant_q : '0;
  assign bus.out_last  = in_burst & last_beat;
  assign bus.src_ren   = hs ? (NUM_SRC'(1) << grant_q) : '0;

  assign busy        = in_burst;
  assign burst_abort = abort_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_rdy) begin
          grant_d = pick;
          rr_d    = pick;
          len_d   = (cfg_burst_len == '0) ? BLW'(1) : cfg_burst_len;
          beat_d  = '0;
          stall_d = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (hs) begin
          beat_d  = beat_q + 1'b1;
          stall_d = '0;
          if (last_beat) begin
            state_d = S_IDLE;
          end
        end else if (!cur_rdy) begin
          // Only an empty source counts as starvation; consumer backpressure
          // leaves the stall counter untouched.
          if ((cfg_timeout != '0) && (stall_q == (cfg_timeout - 1'b1))) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= SRCW'(NUM_SRC - 1);
      len_q   <= BLW'(1);
      beat_q  <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_collector_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_collector_drain_sched
// Drives queue-backed FWFT sources and a random/directed consumer, and
// compares every cycle against a transaction-level model of the scheduler.
// ---------------------------------------------------------------------------
module tb_collector_drain_sched;
  localparam int NS  = 4;
  localparam int DW  = 64;
  localparam int BLW = 8;
  localparam int TOW = 10;
  localparam int SW  = $clog2(NS);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [BLW-1:0] cfg_burst_len;
  logic [TOW-1:0] cfg_timeout;
  logic           burst_abort;
  logic           busy;

  collector_drain_if #(.NUM_SRC(NS), .DATAW(DW)) dif ();

  collector_drain_sched #(.NUM_SRC(NS), .DATAW(DW), .BLW(BLW), .TOW(TOW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_burst_len (cfg_burst_len),
    .cfg_timeout   (cfg_timeout),
    .burst_abort   (burst_abort),
    .busy          (busy),
    .bus           (dif.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo [NS][$];
  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  int seq = 0;

  // model: one burst = (source, length); counts sent words and starved cycles
  bit m_busy, m_abort;
  int m_src, m_len, m_sent, m_starve, m_rr;
  int grant_log[$];
  int n_pop, n_last, n_abort, n_dpop;

  logic          s_valid, s_last, s_busy, s_abort;
  logic [SW-1:0] s_src;
  logic [NS-1:0] s_ren;
  logic [DW-1:0] s_data;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(int s, int n);
    repeat (n) begin
      fifo[s].push_back({16'(s), 16'hC0DE, 32'(seq)});
      seq++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_src = 0; m_len = 1;
    m_sent = 0; m_starve = 0; m_rr = NS - 1;
  endtask

  task automatic step();
    bit            e_valid, e_last, e_hs, found;
    logic [NS-1:0] e_ren;
    logic [DW-1:0] e_data;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      dif.src_rdy[i] = (fifo[i].size() > 0);
      dif.src_rdata[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
    end
    #1;
    s_valid = dif.out_valid; s_last = dif.out_last; s_busy = busy;
    s_abort = burst_abort;   s_src = dif.out_src;   s_ren = dif.src_ren;
    s_data  = dif.out_data;
    e_valid = m_busy && (fifo[m_src].size() > 0);
    e_data  = e_valid ? fifo[m_src][0] : '0;
    e_last  = m_busy && (m_sent == m_len - 1);
    e_hs    = e_valid && dif.out_ready;
    e_ren   = e_hs ? (NS'(1) << m_src) : '0;
    if (chk_on) begin
      chk("out_valid", 64'(s_valid), 64'(e_valid));
      chk("busy", 64'(s_busy), 64'(m_busy));
      chk("burst_abort", 64'(s_abort), 64'(m_abort));
      chk("src_ren", 64'(s_ren), 64'(e_ren));
      if (m_busy) chk("out_src", 64'(s_src), 64'(m_src));
      if (e_valid) begin
        chk("out_data", 64'(s_data), 64'(e_data));
        chk("out_last", 64'(s_last), 64'(e_last));
      end
    end
    @(posedge clk);
    n_dpop += $countones(s_ren);
    for (int i = 0; i < NS; i++)
      if (s_ren[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    if (rst) begin
      model_reset();
    end else begin
      m_abort = 0;
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= NS; k++) begin
          if (!found && dif.src_rdy[(m_rr + k) % NS]) begin
            found = 1;
            m_src = (m_rr + k) % NS;
          end
        end
        if (found) begin
          m_rr = m_src; m_busy = 1; m_sent = 0; m_starve = 0;
          m_len = (cfg_burst_len == 0) ? 1 : int'(cfg_burst_len);
          grant_log.push_back(m_src);
        end
      end else if (e_hs) begin
        n_pop++;
        m_sent++;
        m_starve = 0;
        if (e_last) begin
          n_last++;
          m_busy = 0;
        end
      end else if (!e_valid) begin
        if (cfg_timeout != 0 && m_starve + 1 == int'(cfg_timeout)) begin
          m_busy = 0; m_abort = 1; n_abort++;
        end else begin
          m_starve++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NS; i++) fifo[i].delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_on = 1;
    step();
    chk("rst_out_valid", 64'(s_valid), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_src_ren", 64'(s_ren), 64'd0);
    chk("rst_out_src", 64'(s_src), 64'd0);
    chk("rst_abort", 64'(s_abort), 64'd0);
    grant_log.delete();
    n_pop = 0; n_last = 0; n_abort = 0; n_dpop = 0;
  endtask

  initial begin
    logic [DW-1:0] w1;
    bit rdy_seq [6];
    model_reset();
    cfg_burst_len = 8'd4;
    cfg_timeout   = '0;
    dif.out_ready = 1'b1;
    dif.src_rdy   = '0;
    dif.src_rdata = '0;

    // single source, 8 words, len 4
    do_reset();
    push(0, 8);
    repeat (10) step();
    chk("t1_fifo_empty", 64'(fifo[0].size()), 64'd0);
    chk("t1_pops", 64'(n_dpop), 64'd8);
    chk("t1_lasts", 64'(n_last), 64'd2);
    chk("t1_grants", 64'(grant_log.size()), 64'd2);

    // all ready, len 2 -> 0,1,2,3,0
    do_reset();
    cfg_burst_len = 8'd2;
    for (int s = 0; s < NS; s++) push(s, 4);
    repeat (15) step();
    chk("t2_ngrant", 64'(grant_log.size()), 64'd5);
    for (int g = 0; g < 5 && g < grant_log.size(); g++)
      chk("t2_grant_order", 64'(grant_log[g]), 64'(g % NS));
    chk("t2_pops", 64'(n_dpop), 64'd10);

    // len 3 with backpressure 1,0,0,1,1
    do_reset();
    cfg_burst_len = 8'd3;
    push(2, 3);
    w1 = fifo[2][1];
    rdy_seq = '{1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      dif.out_ready = rdy_seq[i];
      step();
      if (i == 2 || i == 3) chk("t3_hold_data", 64'(s_data), 64'(w1));
    end
    dif.out_ready = 1'b1;
    chk("t3_pops", 64'(n_dpop), 64'd3);
    chk("t3_lasts", 64'(n_last), 64'd1);
    chk("t3_aborts", 64'(n_abort), 64'd0);

    // len 4, timeout 5, only 2 words
    do_reset();
    cfg_burst_len = 8'd4;
    cfg_timeout   = 10'd5;
    push(1, 2);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 7) chk("t4_busy_before_abort", 64'(s_busy), 64'd1);
      if (i == 8) begin
        chk("t4_abort_pulse", 64'(s_abort), 64'd1);
        chk("t4_idle_after_abort", 64'(s_busy), 64'd0);
      end
      if (i == 9) chk("t4_abort_single", 64'(s_abort), 64'd0);
    end
    chk("t4_pops", 64'(n_dpop), 64'd2);
    chk("t4_lasts", 64'(n_last), 64'd0);
    chk("t4_aborts", 64'(n_abort), 64'd1);
    cfg_timeout = '0;

    // len 0 -> single-beat bursts
    do_reset();
    cfg_burst_len = 8'd0;
    push(3, 3);
    repeat (6) step();
    chk("t5_lasts", 64'(n_last), 64'd3);
    chk("t5_pops", 64'(n_dpop), 64'd3);

    // reset mid-burst, len 8
    do_reset();
    cfg_burst_len = 8'd8;
    push(0, 10);
    push(2, 2);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t6_valid_after_rst", 64'(s_valid), 64'd0);
    chk("t6_ren_after_rst", 64'(s_ren), 64'd0);
    chk("t6_busy_after_rst", 64'(s_busy), 64'd0);
    chk("t6_ngrant", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) chk("t6_regrant_src0", 64'(grant_log[1]), 64'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) cfg_burst_len = BLW'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) cfg_timeout = TOW'($urandom_range(0, 6));
      dif.out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 2) == 0 && fifo[s].size() < 6) push(s, 1);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/collector_drain_sched.md
Name: collector_drain_sched

Overview:
Round-robin drain scheduler that shares one downstream consumer port (e.g. an MVM tile input) among NUM_SRC collector data FIFOs. Grants one source at a time and moves a burst of cfg_burst_len words from it to the consumer over a valid/ready interface, with beat framing and source tagging. Sits between the per-link collector FIFOs and the compute datapath. A stall timeout releases a grant that has starved.

Parameters:
NUM_SRC, 4, number of collector FIFOs arbitrated (>=2)
DATAW, 512, data word width
BLW, 8, width of cfg_burst_len and beat counter
TOW, 10, width of stall timeout counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_burst_len  in  BLW  words per grant; sampled at grant; 0 treated as 1
cfg_timeout  in  TOW  max consecutive starved cycles in a burst; 0 disables timeout
src_rdy  in  NUM_SRC  per-source FIFO non-empty; head word valid on src_rdata
src_rdata  in  NUM_SRC*DATAW  per-source head words, source i at [i*DATAW +: DATAW]
src_ren  out  NUM_SRC  per-source pop, one-hot or zero
out_valid  out  1  downstream word valid
out_data  out  DATAW  downstream word
out_src  out  $clog2(NUM_SRC)  index of source for the current word
out_last  out  1  final beat of burst; qualified by out_valid
out_ready  in  1  downstream accept
burst_abort  out  1  1-cycle pulse when a burst is released by timeout
busy  out  1  high in BURST state

Behaviour:
- Source FIFOs are first-word-fall-through: head word is valid while src_rdy=1, and src_ren pops it at the clock edge.
- States: IDLE, BURST.
- Reset: state=IDLE, rr pointer=NUM_SRC-1, beat/stall counters=0, out_valid=0, src_ren=0, out_last=0, burst_abort=0, busy=0, out_src=0.
- IDLE, no src_rdy bit set: stay in IDLE.
- IDLE, any src_rdy bit set:
  - Pick the first set bit searching upward from rr_ptr+1, mod NUM_SRC.
  - Register grant, set rr_ptr=grant, latch len=max(cfg_burst_len,1), clear counters, go to BURST.
  - No data moves in the IDLE cycle, so the grant-to-first-beat latency is 1 cycle.
- BURST outputs (combinational from registered grant):
  - out_valid=src_rdy[grant]; out_data=src_rdata[grant]; out_src=grant.
  - out_last=(beat==len-1).
  - src_ren[grant]=out_valid&out_ready; all other src_ren bits are 0.
- BURST on a handshake (out_valid&out_ready):
  - beat increments and the stall counter clears.
  - If out_last, go to IDLE; exactly len words per completed burst.
- BURST with src_rdy[grant]=0:
  - stall counter increments.
  - If cfg_timeout!=0 and the stall counter reaches cfg_timeout-1 in a starved cycle, pulse burst_abort next cycle and go to IDLE.
  - Words already sent stay sent; no out_last is issued for the aborted burst.
- BURST with out_valid=1 and out_ready=0: downstream backpressure, not a stall.
  - Hold state, do not pop, do not count toward timeout.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- cfg_burst_len or cfg_timeout changes mid-burst: no effect on the current burst (len latched at grant); cfg_timeout is read live for the stall comparison.
- Fairness: a source just served is lowest priority at the next arbitration. With all sources always ready, the grant order is 0,1,2,...,NUM_SRC-1,0.
- Idle cycle: there is a mandatory 1-cycle IDLE between bursts. Sustained throughput is len/(len+1).
- src_ren must never assert for a source whose src_rdy=0.
- Reset mid-burst: return to IDLE next cycle with all outputs at reset values. The partial burst is abandoned; the consumer must also be reset.

Test Plan:
- Reset, src_rdy=0001, 8 words queued, len=4, out_ready=1 -> IDLE 1 cycle, then 4 beats, out_src=0, out_last on beat 4, then IDLE, then another 4 beats.
- All sources ready, len=2 -> bursts granted 0,1,2,3,0; each burst is 2 beats with out_last on the 2nd; one idle cycle between bursts.
- len=3, out_ready toggling 1,0,0,1,1 -> src_ren only on accepted cycles, out_data stable while stalled, exactly 3 pops, no burst_abort.
- len=4, timeout=5, source supplies 2 words then empties -> after 5 starved cycles burst_abort pulses once, state=IDLE, 2 pops total, no out_last.
- cfg_burst_len=0 -> single-beat bursts with out_last on every beat.
- rst asserted after beat 2 of a len=8 burst -> next cycle out_valid=0, src_ren=0, busy=0; after release the pointer restarts and source 0 is granted first.
